// File: rtl/writeback_stage.sv
// Writeback stage: registers the MEM/WB bundle, formats load data, writes the
// integer register file and serves two bypassed combinational read ports.
// Also counts retired instructions.
module writeback_stage #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,             // async, active-low
  input  logic            MEMWB_ready,
  input  logic [XLEN-1:0] memwb_aluresult,
  input  logic [XLEN-1:0] memwb_loadeddata,
  input  logic [5:0]      memwb_rd,
  input  logic            memwb_isload,
  input  logic [2:0]      memwb_funct3,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            wb_valid,
  output logic [5:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [63:0]     retired_count
);

  typedef struct packed {
    logic [XLEN-1:0] aluresult;
    logic [XLEN-1:0] loadeddata;
    logic [5:0]      rd;
    logic            isload;
    logic [2:0]      funct3;
  } bundle_t;

  // Load funct3 encodings (RV64 LB..LWU)
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } load_f3_e;

  bundle_t         bundle_q, bundle_d;
  logic            valid_q, valid_d;
  logic [63:0]     retired_count_q, retired_count_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  logic            wr_en;
  logic [XLEN-1:0] result;

  // Extract the addressed lane from an aligned doubleword; low offset bits
  // below the access size are ignored, so every lane is naturally aligned.
  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] data,
                                               input logic [2:0]      off,
                                               input logic [2:0]      f3);
    logic [XLEN-1:0] sh_b;
    logic [XLEN-1:0] sh_h;
    logic [XLEN-1:0] sh_w;
    logic [XLEN-1:0] res;
    sh_b = data >> {off, 3'b000};
    sh_h = data >> {off[2:1], 4'b0000};
    sh_w = data >> {off[2], 5'b00000};
    case (f3)
      F3_LB:   res = {{(XLEN-8){sh_b[7]}},   sh_b[7:0]};
      F3_LH:   res = {{(XLEN-16){sh_h[15]}}, sh_h[15:0]};
      F3_LW:   res = {{(XLEN-32){sh_w[31]}}, sh_w[31:0]};
      F3_LD:   res = data;
      F3_LBU:  res = {{(XLEN-8){1'b0}},      sh_b[7:0]};
      F3_LHU:  res = {{(XLEN-16){1'b0}},     sh_h[15:0]};
      F3_LWU:  res = {{(XLEN-32){1'b0}},     sh_w[31:0]};
      default: res = '0;                     // 111 is reserved
    endcase
    return res;
  endfunction

  // Result selection and write enable for the instruction currently in WB
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    result = bundle_q.aluresult;
    if (bundle_q.isload) begin
      result = fmt_load(bundle_q.loadeddata, bundle_q.aluresult[2:0], bundle_q.funct3);
    end
    wr_en = valid_q & ~bundle_q.rd[5] & (bundle_q.rd[4:0] != 5'd0);
  end

  // Next-state for the stage register: capture on ready, hold on bubble
  always_comb begin
    bundle_d = bundle_q;
    valid_d  = MEMWB_ready;
    if (MEMWB_ready) begin
      bundle_d.aluresult  = memwb_aluresult;
      bundle_d.loadeddata = memwb_loadeddata;
      bundle_d.rd         = memwb_rd;
      bundle_d.isload     = memwb_isload;
      bundle_d.funct3     = memwb_funct3;
    end
  end

  // Next-state for the register file; x0 is pinned to zero
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[bundle_q.rd[4:0]] = result;
    end
    regs_d[0] = '0;
  end

  // Retired counter: every valid WB instruction counts, wrapping naturally
  always_comb begin
    retired_count_d = retired_count_q;
    if (valid_q) begin
      retired_count_d = retired_count_q + 64'd1;
    end
  end

  // Stage register and retired counter
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      bundle_q        <= '0;
      valid_q         <= 1'b0;
      retired_count_q <= '0;
    end else begin
      bundle_q        <= bundle_d;
      valid_q         <= valid_d;
      retired_count_q <= retired_count_d;
    end
  end

  // Register file storage
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the register file is architecturally cleared on reset, so it is
    // built from resettable flops rather than an inferred RAM macro.
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports with same-cycle bypass from the instruction being written
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    rs2_data = regs_q[rs2_addr];
    if (wr_en && bundle_q.rd[4:0] == rs1_addr) rs1_data = result;
    if (wr_en && bundle_q.rd[4:0] == rs2_addr) rs2_data = result;
    if (rs1_addr == 5'd0) rs1_data = '0;
    if (rs2_addr == 5'd0) rs2_data = '0;
  end

  assign wb_valid      = valid_q;
  assign wb_rd         = bundle_q.rd;
  assign wb_data       = result;
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage.
module tb_writeback_stage;

  logic        clk;
  logic        reset;
  logic        MEMWB_ready;
  logic [63:0] memwb_aluresult;
  logic [63:0] memwb_loadeddata;
  logic [5:0]  memwb_rd;
  logic        memwb_isload;
  logic [2:0]  memwb_funct3;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        wb_valid;
  logic [5:0]  wb_rd;
  logic [63:0] wb_data;
  logic [63:0] retired_count;

  int vectors    = 0;
  int miscompares = 0;
  logic [63:0] exp_retired = 64'd0;

  writeback_stage dut (
    .clk              (clk),
    .reset            (reset),
    .MEMWB_ready      (MEMWB_ready),
    .memwb_aluresult  (memwb_aluresult),
    .memwb_loadeddata (memwb_loadeddata),
    .memwb_rd         (memwb_rd),
    .memwb_isload     (memwb_isload),
    .memwb_funct3     (memwb_funct3),
    .rs1_addr         (rs1_addr),
    .rs2_addr         (rs2_addr),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .retired_count    (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] LDATA = 64'h8877_6655_4433_2281;
  localparam int NLD = 12;
  localparam logic [2:0]  LD_F3  [NLD] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b001,
                                           3'b110, 3'b010, 3'b010, 3'b111, 3'b100, 3'b011};
  localparam logic [63:0] LD_ALU [NLD] = '{64'h1003, 64'h1000, 64'h1000, 64'h1006, 64'h1001, 64'h1003,
                                           64'h1004, 64'h1004, 64'h1000, 64'h1000, 64'h1007, 64'h1005};
  localparam logic [63:0] LD_EXP [NLD] = '{64'h44, 64'hFFFF_FFFF_FFFF_FF81, 64'h81,
                                           64'hFFFF_FFFF_FFFF_8877, 64'h2281, 64'h4433,
                                           64'h8877_6655, 64'hFFFF_FFFF_8877_6655, 64'h4433_2281,
                                           64'h0, 64'h88, 64'h8877_6655_4433_2281};

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ready, input logic [5:0] rd, input logic [63:0] alu,
                       input logic isload, input logic [2:0] f3, input logic [63:0] ld);
    MEMWB_ready      = ready;
    memwb_rd         = rd;
    memwb_aluresult  = alu;
    memwb_isload     = isload;
    memwb_funct3     = f3;
    memwb_loadeddata = ld;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 6'd0, 64'd0, 1'b0, 3'd0, 64'd0);
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    vectors++;
    if (wb_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_wb_valid got %0b want 0", wb_valid);
    end
    vectors++;
    if (retired_count !== 64'd0) begin
      miscompares++; $display("FAIL reset_retired got %0h want 0", retired_count);
    end
    vectors++;
    if (wb_rd !== 6'd0 || wb_data !== 64'd0) begin
      miscompares++; $display("FAIL reset_bundle got rd=%0h data=%0h want 0/0", wb_rd, wb_data);
    end
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      vectors++;
      if (rs1_data !== 64'd0 || rs2_data !== 64'd0) begin
        miscompares++;
        $display("FAIL reset_reg%0d got %0h/%0h want 0/0", i, rs1_data, rs2_data);
      end
    end
  endtask

  task automatic test_alu_bypass();
    drive(1'b1, 6'd5, 64'h1234, 1'b0, 3'b011, 64'hDEAD_BEEF);
    tick();
    MEMWB_ready = 1'b0;
    rs1_addr    = 5'd5;
    #1;
    vectors++;
    if (wb_valid !== 1'b1 || wb_data !== 64'h1234) begin
      miscompares++; $display("FAIL alu_wb got valid=%0b data=%0h want 1/1234", wb_valid, wb_data);
    end
    vectors++;
    if (rs1_data !== 64'h1234) begin
      miscompares++; $display("FAIL alu_bypass got %0h want 1234", rs1_data);
    end
    vectors++;
    if (retired_count !== exp_retired) begin
      miscompares++; $display("FAIL alu_retired_early got %0h want %0h", retired_count, exp_retired);
    end
    tick();
    exp_retired++;
    vectors++;
    if (rs1_data !== 64'h1234 || wb_valid !== 1'b0) begin
      miscompares++; $display("FAIL alu_regfile got %0h valid=%0b want 1234/0", rs1_data, wb_valid);
    end
    vectors++;
    if (retired_count !== exp_retired) begin
      miscompares++; $display("FAIL alu_retired got %0h want %0h", retired_count, exp_retired);
    end
  endtask

  task automatic test_loads();
    for (int i = 0; i < NLD; i++) begin
      drive(1'b1, 6'd10, LD_ALU[i], 1'b1, LD_F3[i], LDATA);
      tick();
      vectors++;
      if (wb_data !== LD_EXP[i]) begin
        miscompares++;
        $display("FAIL load%0d f3=%0b alu=%0h got %0h want %0h", i, LD_F3[i], LD_ALU[i], wb_data, LD_EXP[i]);
      end
      exp_retired++;
    end
    MEMWB_ready = 1'b0;
    rs1_addr    = 5'd10;
    tick();
    vectors++;
    if (rs1_data !== LDATA) begin
      miscompares++; $display("FAIL load_regfile got %0h want %0h", rs1_data, LDATA);
    end
    vectors++;
    if (retired_count !== exp_retired) begin
      miscompares++; $display("FAIL load_retired got %0h want %0h", retired_count, exp_retired);
    end
  endtask

  task automatic test_no_write();
    drive(1'b1, 6'd3, 64'hABC, 1'b0, 3'd0, 64'd0);
    tick();
    exp_retired++;
    drive(1'b1, 6'd0, 64'hFF, 1'b0, 3'd0, 64'd0);
    tick();
    exp_retired++;
    rs1_addr = 5'd0;
    rs2_addr = 5'd3;
    #1;
    vectors++;
    if (rs1_data !== 64'd0 || rs2_data !== 64'hABC) begin
      miscompares++; $display("FAIL x0_write got x0=%0h x3=%0h want 0/abc", rs1_data, rs2_data);
    end
    drive(1'b1, 6'h23, 64'hDEAD, 1'b0, 3'd0, 64'd0);
    tick();
    exp_retired++;
    vectors++;
    if (wb_valid !== 1'b1 || wb_rd !== 6'h23 || rs2_data !== 64'hABC) begin
      miscompares++;
      $display("FAIL nowrite_bypass got valid=%0b rd=%0h x3=%0h want 1/23/abc", wb_valid, wb_rd, rs2_data);
    end
    MEMWB_ready = 1'b0;
    tick();
    vectors++;
    if (rs1_data !== 64'd0 || rs2_data !== 64'hABC) begin
      miscompares++; $display("FAIL nowrite_regs got x0=%0h x3=%0h want 0/abc", rs1_data, rs2_data);
    end
    vectors++;
    if (retired_count !== exp_retired) begin
      miscompares++; $display("FAIL nowrite_retired got %0h want %0h", retired_count, exp_retired);
    end
  endtask

  task automatic test_back_to_back();
    rs1_addr = 5'd7;
    rs2_addr = 5'd7;
    for (int v = 1; v <= 3; v++) begin
      drive(1'b1, 6'd7, 64'(v), 1'b0, 3'd0, 64'd0);
      tick();
      exp_retired++;
      vectors++;
      if (wb_data !== 64'(v) || rs1_data !== 64'(v) || rs2_data !== 64'(v)) begin
        miscompares++;
        $display("FAIL b2b_%0d got wb=%0h rs1=%0h rs2=%0h want %0d", v, wb_data, rs1_data, rs2_data, v);
      end
    end
    // Bubble with junk on the inputs: bundle must hold
    drive(1'b0, 6'd9, 64'h99, 1'b1, 3'b001, 64'hFFFF);
    tick();
    vectors++;
    if (wb_valid !== 1'b0 || wb_rd !== 6'd7 || wb_data !== 64'd3) begin
      miscompares++;
      $display("FAIL bubble_hold got valid=%0b rd=%0h data=%0h want 0/7/3", wb_valid, wb_rd, wb_data);
    end
    vectors++;
    if (rs1_data !== 64'd3) begin
      miscompares++; $display("FAIL b2b_x7 got %0h want 3", rs1_data);
    end
    tick();
    vectors++;
    if (retired_count !== exp_retired) begin
      miscompares++; $display("FAIL b2b_retired got %0h want %0h", retired_count, exp_retired);
    end
  endtask

  task automatic test_reset_midstream();
    rs1_addr = 5'd9;
    drive(1'b1, 6'd9, 64'h5555, 1'b0, 3'd0, 64'd0);
    tick();
    MEMWB_ready = 1'b0;
    vectors++;
    if (wb_valid !== 1'b1) begin
      miscompares++; $display("FAIL mid_valid got %0b want 1", wb_valid);
    end
    #1;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    exp_retired = 64'd0;
    tick();
    vectors++;
    if (rs1_data !== 64'd0 || retired_count !== 64'd0 || wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset got x9=%0h retired=%0h valid=%0b want 0/0/0", rs1_data, retired_count, wb_valid);
    end
  endtask

  task automatic test_wrap();
    force dut.retired_count_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retired_count_q;
    #1;
    vectors++;
    if (retired_count !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      miscompares++; $display("FAIL wrap_preset got %0h want ffffffffffffffff", retired_count);
    end
    drive(1'b1, 6'd1, 64'h11, 1'b0, 3'd0, 64'd0);
    tick();
    drive(1'b1, 6'd2, 64'h22, 1'b0, 3'd0, 64'd0);
    tick();
    MEMWB_ready = 1'b0;
    tick();
    vectors++;
    if (retired_count !== 64'd1) begin
      miscompares++; $display("FAIL wrap got %0h want 1", retired_count);
    end
    rs1_addr = 5'd1;
    rs2_addr = 5'd2;
    #1;
    vectors++;
    if (rs1_data !== 64'h11 || rs2_data !== 64'h22) begin
      miscompares++; $display("FAIL wrap_regs got %0h/%0h want 11/22", rs1_data, rs2_data);
    end
  endtask

  initial begin
    test_reset();
    test_alu_bypass();
    test_loads();
    test_no_write();
    test_back_to_back();
    test_reset_midstream();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
